// File: rtl/fa_pipe_nbit.sv
// Pipelined N-bit adder/subtractor.
// The operands are split into STAGES equal slices and one slice is added per clock.
// The carry is registered between slices, so the critical path is one SW-bit adder.
// The operands travel forward with the partial sum, and each stage fills in its own slice of the result.
// The last stage register is the output register. Add or subtract is chosen per operation.
// A valid/ready handshake with a single global enable stalls the whole pipe.
module fa_pipe_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    logic              en;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  opA_q [STAGES];
    logic [WIDTH-1:0]  opA_d [STAGES];
    logic [WIDTH-1:0]  opB_q [STAGES];
    logic [WIDTH-1:0]  opB_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              stgVld;
    logic [WIDTH-1:0]  stgA;
    logic [WIDTH-1:0]  stgB;
    logic [WIDTH-1:0]  stgSum;
    logic              stgCin;
    logic [SW:0]       sliceRes;

    // The pipe moves as one whole unit whenever the output slot is empty or being drained, so nothing ever overtakes anything else.
    assign en        = out_ready | ~vld_q[STAGES-1];
    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign so        = sum_q[STAGES-1];
    assign co        = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // Walk the slice chain. Stage 0 is fed from the ports, with B and the carry-in inverted for subtraction.
    // Every later stage is fed from the register of the stage before it.
    always_comb begin
        stgVld   = in_valid;
        stgA     = a;
        stgB     = b ^ {WIDTH{sub}};
        stgCin   = ci ^ sub;
        stgSum   = '0;
        sliceRes = '0;
        ovf_d    = 1'b0;
        vld_d    = '0;
        carry_d  = '0;
        for (int k = 0; k < STAGES; k++) begin
            sliceRes   = {1'b0, stgA[k*SW +: SW]} + {1'b0, stgB[k*SW +: SW]}
                       + {{SW{1'b0}}, stgCin};
            vld_d[k]   = stgVld;
            opA_d[k]   = stgA;
            opB_d[k]   = stgB;
            sum_d[k]   = stgSum;
            sum_d[k][k*SW +: SW] = sliceRes[SW-1:0];
            carry_d[k] = sliceRes[SW];
            if (k == STAGES - 1) begin
                ovf_d = (stgA[WIDTH-1] == stgB[WIDTH-1])
                      && (sliceRes[SW-1] != stgA[WIDTH-1]);
            end
            stgVld = vld_q[k];
            stgA   = opA_q[k];
            stgB   = opB_q[k];
            stgSum = sum_q[k];
            stgCin = carry_q[k];
        end
    end

    // Stage registers: a synchronous reset flushes every in-flight operation, and otherwise all stages advance together on enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (en) begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= opA_d[k];
                opB_q[k] <= opB_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fa_pipe_nbit.sv
// Testbench for fa_pipe_nbit. Three instances share the same stimulus: STAGES=4 (main), STAGES=1 and STAGES=16.
// The auxiliary instances always have their output accepted.
module tb_fa_pipe_nbit;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] so;
        logic         co;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] so;
        logic         co;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         outReady;
    logic         auxReady;
    logic [2:0]   inReadyV;
    logic [2:0]   outValidV;
    logic [2:0]   coV;
    logic [2:0]   ovfV;
    logic [W-1:0] soV [3];

    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    bit   latChkMain = 1'b0;

    res_t fifoRes  [3][64];
    int   fifoEdge [3][64];
    int   head [3];
    int   tail [3];

    always #5 clk = ~clk;

    fa_pipe_nbit #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyV[0]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(outValidV[0]),
        .out_ready(outReady), .so(soV[0]), .co(coV[0]), .ovf(ovfV[0]));

    fa_pipe_nbit #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyV[1]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(outValidV[1]),
        .out_ready(auxReady), .so(soV[1]), .co(coV[1]), .ovf(ovfV[1]));

    fa_pipe_nbit #(.WIDTH(W), .STAGES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyV[2]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(outValidV[2]),
        .out_ready(auxReady), .so(soV[2]), .co(coV[2]), .ovf(ovfV[2]));

    function automatic int stgOf(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference model from plain integer arithmetic: the exact sum or difference, then the signed range test.
    function automatic res_t refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                      input logic rci, input logic rsub);
        res_t r;
        int   ua, ub, sa, sb, full, sres;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        if (!rsub) begin
            full = ua + ub + int'(rci);
            r.co = (full > 65535);
            sres = sa + sb + int'(rci);
        end else begin
            full = ua - ub - int'(rci);
            r.co = (full >= 0);
            sres = sa - sb - int'(rci);
        end
        r.so  = full[W-1:0];
        r.ovf = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edgeCnt++;

    // Scoreboard: at each falling edge, decide which transfers the next rising edge will make.
    // An accepted operation is pushed with its model result. A handed-off result is popped and compared.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                head[i] = 0;
                tail[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic rdy;
                res_t e;
                rdy = (i == 0) ? outReady : auxReady;
                if (outValidV[i] && rdy) begin
                    if (tail[i] == head[i]) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL dut%0d_spurious: got a result, expected none pending", i);
                    end else begin
                        e = fifoRes[i][head[i] % 64];
                        checkOutput($sformatf("dut%0d_result", i),
                                    {14'd0, soV[i], coV[i], ovfV[i]}, {14'd0, e});
                        if (i != 0 || latChkMain)
                            checkOutput($sformatf("dut%0d_latency_edge", i), edgeCnt,
                                        fifoEdge[i][head[i] % 64] + stgOf(i) - 1);
                        head[i]++;
                    end
                end
                if (in_valid && inReadyV[i]) begin
                    fifoRes[i][tail[i] % 64]  = refModel(a, b, ci, sub);
                    fifoEdge[i][tail[i] % 64] = edgeCnt + 1;
                    tail[i]++;
                end
            end
        end
    end

    task automatic driveOp(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input logic tsub);
        a        = ta;
        b        = tb_;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
    endtask

    task automatic waitAccept();
        logic acc;
        int   guard;
        guard = 0;
        do begin
            @(negedge clk);
            acc = inReadyV[0];
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input logic tsub);
        driveOp(ta, tb_, tci, tsub);
        waitAccept();
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (((tail[0] != head[0]) || (tail[1] != head[1]) || (tail[2] != head[2])) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("dut%0d_drain_pending", i), tail[i] - head[i], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [10];
        res_t firstRes;
        int   edges;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;
        sub      = 1'b0;
        outReady = 1'b0;
        auxReady = 1'b1;

        // Hold reset for three edges, then check that the outputs are cleared and in_ready stays high.
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset_out_valid", outValidV[0], 0);
            checkOutput("reset_so", soV[0], 0);
            checkOutput("reset_co", coV[0], 0);
            checkOutput("reset_ovf", ovfV[0], 0);
            checkOutput("reset_in_ready", inReadyV[0], 1);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_out_valid", outValidV, 3'b000);
        checkOutput("post_reset_in_ready", inReadyV[0], 1);
        @(posedge clk);
        #1;
        outReady   = 1'b1;
        latChkMain = 1'b1;

        // Directed vectors: each is sent alone, and its latency and result are checked against hand-computed values.
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sub);
            edges = 1;
            while (!outValidV[0] && edges < 40) begin
                @(posedge clk);
                #1;
                edges++;
            end
            checkOutput($sformatf("vec%0d_latency", v), edges, 4);
            checkOutput($sformatf("vec%0d_so", v), soV[0], vecs[v].so);
            checkOutput($sformatf("vec%0d_co", v), coV[0], vecs[v].co);
            checkOutput($sformatf("vec%0d_ovf", v), ovfV[0], vecs[v].ovf);
        end
        waitDrain();

        // Sixteen back-to-back random operations with the output always accepted.
        for (int n = 0; n < 16; n++)
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        waitDrain();

        // Fill the pipe while the output is blocked, hold the stall for five cycles, then release it.
        latChkMain = 1'b0;
        outReady   = 1'b0;
        driveOp(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        firstRes = refModel(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitAccept();
        for (int n = 0; n < 3; n++)
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        driveOp(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", inReadyV[0], 0);
            checkOutput("stall_out_valid", outValidV[0], 1);
            checkOutput("stall_frozen_result", {14'd0, soV[0], coV[0], ovfV[0]}, {14'd0, firstRes});
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        waitAccept();
        waitDrain();

        // Assert reset with three operations in flight: nothing may come out afterwards.
        latChkMain = 1'b1;
        for (int n = 0; n < 3; n++)
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flush_out_valid", outValidV[0], 0);
        checkOutput("flush_in_ready", inReadyV[0], 1);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("flush_no_stale", outValidV, 3'b000);
        end
        @(posedge clk);
        #1;

        // Random handshake traffic on both sides for the main instance.
        latChkMain = 1'b0;
        for (int c = 0; c < 300; c++) begin
            outReady = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            ci       = 1'($urandom);
            sub      = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        outReady = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
